// File: rtl/debounced_up_counter.sv
// Modulo-MODULUS up counter stepped by a raw switch: 2-flop synchroniser, debounce FSM
// emitting one registered pulse per accepted press, then a load/step counter with wrap strobe.
module debounced_up_counter #(
  parameter int WIDTH           = 4,
  parameter int MODULUS         = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             step_pulse
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  logic             sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step_pulse_q, step_pulse_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             load_in_range;

  // Debounce: a level is accepted only after the counter survives DEBOUNCE_CYCLES more
  // samples at that level; any contrary sample while waiting falls back to the old level.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_pulse_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = HIGH;
          step_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  assign load_in_range = ({1'b0, load_val} < (WIDTH + 1)'(MODULUS));

  // Load wins over a coincident step; out-of-range loads saturate to the top count.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = load_in_range ? load_val : Q_MAX;
    end else if (step_pulse_q && en) begin
      if (q_q == Q_MAX) begin
        q_d  = '0;
        tc_d = 1'b1;
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= IDLE_LOW;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
      q_q          <= '0;
      tc_q         <= 1'b0;
    end else begin
      sync1_q      <= step_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
      q_q          <= q_d;
      tc_q         <= tc_d;
    end
  end

  assign q          = q_q;
  assign tc         = tc_q;
  assign step_pulse = step_pulse_q;

endmodule
